// File: rtl/bin2bcd_seq.sv
// Sequential binary to packed-BCD converter using shift-and-add-3, one input
// bit per clock. Start/busy/done handshake; results are held between runs,
// and values above the displayable range saturate to all nines with ovf set.
module bin2bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [BIN_W-1:0]             bin,
  output logic                         busy,
  output logic                         done,
  output logic [4*DIGITS-1:0]          bcd,
  output logic                         ovf,
  output logic [$clog2(DIGITS+1)-1:0]  ndigits
);

  // Number of decimal digits needed to print v.
  function automatic int dec_digits(input longint v);
    int     n;
    longint t;
    n = 1;
    t = v;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return n;
  endfunction

  localparam int ND_W    = $clog2(DIGITS + 1);
  localparam int IN_DIG  = dec_digits((longint'(1) << BIN_W) - 1);
  // One spare digit above the largest input value keeps the add-3 stage
  // from ever losing a carry; never narrower than the output digit count.
  localparam int BCD_DIG = (IN_DIG + 1 > DIGITS) ? IN_DIG + 1 : DIGITS;
  localparam int BCD_W   = 4 * BCD_DIG;
  localparam int WORK_W  = BCD_W + BIN_W;
  localparam int CNT_W   = $clog2(BIN_W + 1);
  localparam logic [63:0] MAXV = 64'(10**DIGITS - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state_reg, state_next;
  logic [WORK_W-1:0]   work_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                ovf_cap_reg;

  logic                accept;
  logic                finish;
  logic                ovf_in;
  logic [BCD_W-1:0]    adj_bcd;
  logic [WORK_W-1:0]   adj_work;
  logic [WORK_W-1:0]   shifted;
  logic [4*DIGITS-1:0] res_digits;
  logic [ND_W-1:0]     nd_next;

  assign busy   = (state_reg == CONV);
  assign ovf_in = (64'(bin) > MAXV);

  // Add 3 to every BCD nibble that is 5 or more before the shift.
  generate
    for (genvar gi = 0; gi < BCD_DIG; gi++) begin : g_add3
      logic [3:0] nib;
      assign nib = work_reg[BIN_W + 4*gi +: 4];
      assign adj_bcd[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign adj_work   = {adj_bcd, work_reg[BIN_W-1:0]};
  assign shifted    = adj_work << 1;
  assign res_digits = shifted[BIN_W +: 4*DIGITS];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: accept start only when idle, finish after BIN_W shifts.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (cnt_reg == CNT_W'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Significant digit count of the result being loaded.
  always_comb begin
    nd_next = ND_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (res_digits[4*i +: 4] != 4'd0) nd_next = ND_W'(i + 1);
    end
    if (ovf_cap_reg) nd_next = ND_W'(DIGITS);
  end

  // Datapath: capture, shift one bit per clock, then publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_reg    <= '0;
      cnt_reg     <= '0;
      ovf_cap_reg <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      ovf         <= 1'b0;
      ndigits     <= ND_W'(1);
    end else begin
      done <= 1'b0;
      if (accept) begin
        work_reg    <= WORK_W'(bin);
        cnt_reg     <= CNT_W'(BIN_W);
        ovf_cap_reg <= ovf_in;
      end else if (busy) begin
        work_reg <= shifted;
        cnt_reg  <= cnt_reg - CNT_W'(1);
      end
      if (finish) begin
        bcd     <= ovf_cap_reg ? {DIGITS{4'h9}} : res_digits;
        ovf     <= ovf_cap_reg;
        ndigits <= nd_next;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed literal cases, a 3-digit
// saturation instance, and randomized conversions against a decimal model.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 12;
  localparam int DIGITS = 4;
  localparam int ND_W   = $clog2(DIGITS + 1);
  localparam int MAXV   = 10**DIGITS - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start3 = 1'b0;
  logic [BIN_W-1:0] bin = '0, bin3 = '0;
  logic busy, done, ovf, busy3, done3, ovf3;
  logic [4*DIGITS-1:0] bcd;
  logic [11:0] bcd3;
  logic [ND_W-1:0] ndigits;
  logic [1:0] nd3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy), .done(done),
    .bcd(bcd), .ovf(ovf), .ndigits(ndigits)
  );

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bin(bin3), .busy(busy3), .done(done3),
    .bcd(bcd3), .ovf(ovf3), .ndigits(nd3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal model: digits by repeated division, saturating above MAXV.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    if (v > MAXV) return {DIGITS{4'h9}};
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int ref_nd(input int v);
    int n;
    int t;
    if (v > MAXV) return DIGITS;
    n = 1;
    t = v;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return n;
  endfunction

  // Behavioural model: an accepted start yields done BIN_W clocks later.
  int m_left = 0, m_val = 0, m_conv = 0, m_nd = 1;
  logic m_done = 1'b0, m_ovf = 1'b0, m_valid = 1'b0;
  logic [4*DIGITS-1:0] m_bcd = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_bcd = '0; m_ovf = 1'b0; m_nd = 1; m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_bcd  = ref_bcd(m_val);
          m_ovf  = (m_val > MAXV);
          m_nd   = ref_nd(m_val);
          m_conv++;
        end
      end else if (start) begin
        m_val  = int'(bin);
        m_left = BIN_W;
      end
    end
  end

  // Compare every cycle against the model, bcd digit by digit.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_done));
      for (int i = 0; i < DIGITS; i++)
        chk($sformatf("bcd_digit%0d", i), 64'(bcd[4*i +: 4]), 64'(m_bcd[4*i +: 4]));
      chk("ovf", 64'(ovf), 64'(m_ovf));
      chk("ndigits", 64'(ndigits), 64'(m_nd));
    end
  end

  assert property (@(posedge clk) disable iff (rst) done |=> !done)
    else $error("FAIL done_double_pulse at cycle %0d", cyc);

  task automatic wait_done(input string tag, input bit sel, output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (sel ? done3 : done) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: got no done want done within 40 cycles", tag);
    end
  endtask

  task automatic count_done(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(tag, 64'(seen), 64'(0));
  endtask

  task automatic run_conv(input string tag, input bit sel, input int v,
                          input logic [15:0] eb, input logic eo, input int en);
    int c0, c1;
    bit ok;
    @(negedge clk);
    if (sel) begin start3 = 1'b1; bin3 = BIN_W'(v); end
    else     begin start  = 1'b1; bin  = BIN_W'(v); end
    c0 = cyc;
    @(negedge clk);
    start = 1'b0; start3 = 1'b0;
    bin = BIN_W'($urandom); bin3 = BIN_W'($urandom);
    wait_done(tag, sel, c1, ok);
    if (ok) begin
      chk({tag, "_latency"}, 64'(c1 - c0 - 1), 64'(BIN_W));
      chk({tag, "_bcd"}, sel ? 64'(bcd3) : 64'(bcd), 64'(eb));
      chk({tag, "_ovf"}, sel ? 64'(ovf3) : 64'(ovf), 64'(eo));
      chk({tag, "_nd"}, sel ? 64'(nd3) : 64'(ndigits), 64'(en));
    end
  endtask

  initial begin
    int c1, c2, target;
    bit ok1, ok2;
    int edge_vals[8] = '{9, 10, 99, 100, 999, 1000, 4094, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_bcd", 64'(bcd), 64'(16'h0000));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_nd", 64'(ndigits), 64'(1));
    rst = 1'b0;

    // Directed literal conversions
    run_conv("zero", 1'b0, 0, 16'h0000, 1'b0, 1);
    run_conv("max", 1'b0, 4095, 16'h4095, 1'b0, 4);
    run_conv("v1234", 1'b0, 1234, 16'h1234, 1'b0, 4);
    run_conv("v7", 1'b0, 7, 16'h0007, 1'b0, 1);

    // start held high: back-to-back conversions, busy-time starts ignored
    @(negedge clk);
    start = 1'b1; bin = BIN_W'(1000);
    @(negedge clk);
    bin = BIN_W'(250);
    wait_done("b2b_first", 1'b0, c1, ok1);
    if (ok1) begin
      chk("b2b_first_bcd", 64'(bcd), 64'(16'h1000));
      chk("b2b_first_nd", 64'(ndigits), 64'(4));
    end
    wait_done("b2b_second", 1'b0, c2, ok2);
    start = 1'b0;
    if (ok1 && ok2) chk("b2b_period", 64'(c2 - c1), 64'(13));
    if (ok2) begin
      chk("b2b_second_bcd", 64'(bcd), 64'(16'h0250));
      chk("b2b_second_nd", 64'(ndigits), 64'(3));
    end
    count_done("b2b_no_extra_done", 16);

    // Three-digit instance: saturation and the largest representable value
    run_conv("d3_1000", 1'b1, 1000, 16'h0999, 1'b1, 3);
    run_conv("d3_999", 1'b1, 999, 16'h0999, 1'b0, 3);
    run_conv("d3_4095", 1'b1, 4095, 16'h0999, 1'b1, 3);
    run_conv("d3_42", 1'b1, 42, 16'h0042, 1'b0, 2);

    // Reset in the middle of a conversion aborts it
    @(negedge clk);
    start = 1'b1; bin = BIN_W'(3333);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_bcd", 64'(bcd), 64'(16'h0000));
    chk("abort_nd", 64'(ndigits), 64'(1));
    count_done("abort_no_done", 20);
    run_conv("after_abort", 1'b0, 42, 16'h0042, 1'b0, 2);

    // Randomized conversions checked by the model
    target = m_conv + 5000;
    for (int k = 0; k < 90000 && m_conv < target; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       bin = '0;
        1:       bin = '1;
        2:       bin = BIN_W'(edge_vals[$urandom_range(0, 7)]);
        default: bin = BIN_W'($urandom_range(0, 4095));
      endcase
    end
    start = 1'b0;
    total++;
    if (m_conv < target) begin
      bad++;
      $display("FAIL random_budget: got %0d conversions want %0d", m_conv, target);
    end
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
